// File: rtl/mem_stage_if.sv
// Data-memory port between the memory-access stage and the data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready port,
// aligns and extends load data, stalls upstream while an access is pending.
module mem_stage (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      aluResult1_PR,
  input  logic [31:0]      readDataB1_PR,
  input  logic [31:0]      Instr1_PR,
  input  logic [4:0]       writeRegister1_PR,
  input  logic             do_writeback1_PR,
  input  logic             MemRead1_PR,
  input  logic             MemWrite1_PR,
  input  logic             MemtoReg1_PR,
  mem_stage_if.master      dmem,
  output logic             stall_out,
  output logic [31:0]      Data1_MEM,
  output logic [4:0]       writeRegister1_MEM,
  output logic             do_writeback1_MEM,
  output logic [31:0]      Data1_WB,
  output logic [4:0]       writeRegister1_WB,
  output logic             do_writeback1_WB,
  output logic             mem_fault
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [5:0]  opcode;
  logic [1:0]  byte_off;
  logic        is_byte;
  logic        is_half;
  logic        is_signed;
  logic        mem_op;
  logic        misaligned;
  logic        aligned_op;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic        unused_instr_bits;

  assign opcode            = Instr1_PR[31:26];
  assign byte_off          = aluResult1_PR[1:0];
  assign unused_instr_bits = ^Instr1_PR[25:0];

  // Access size and signedness; unrecognised opcodes fall back to word.
  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (opcode)
      6'h20: begin is_byte = 1'b1; is_signed = 1'b1; end
      6'h21: begin is_half = 1'b1; is_signed = 1'b1; end
      6'h24: is_byte = 1'b1;
      6'h25: is_half = 1'b1;
      6'h28: is_byte = 1'b1;
      6'h29: is_half = 1'b1;
      default: ;
    endcase
  end

  // Fault detection: bad alignment for the size, or read and write together.
  always_comb begin
    mem_op     = MemRead1_PR | MemWrite1_PR;
    misaligned = 1'b0;
    if (mem_op) begin
      if (MemRead1_PR && MemWrite1_PR)
        misaligned = 1'b1;
      else if (is_half)
        misaligned = byte_off[0];
      else if (!is_byte)
        misaligned = (byte_off != 2'b00);
    end
    aligned_op = mem_op & ~misaligned;
  end

  // Request stays up through WAIT until ready; reset kills it immediately.
  assign dmem.dmem_req   = RESET & ((state == WAIT) | aligned_op);
  assign dmem.dmem_we    = MemWrite1_PR & ~MemRead1_PR;
  assign dmem.dmem_addr  = {aluResult1_PR[31:2], 2'b00};
  assign stall_out       = dmem.dmem_req & ~dmem.dmem_ready;

  // Store lane enables and lane-replicated write data.
  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = readDataB1_PR;
    if (dmem.dmem_we) begin
      if (is_byte) begin
        dmem.dmem_be    = 4'(4'b0001 << byte_off);
        dmem.dmem_wdata = {4{readDataB1_PR[7:0]}};
      end else if (is_half) begin
        dmem.dmem_be    = 4'(4'b0011 << byte_off);
        dmem.dmem_wdata = {2{readDataB1_PR[15:0]}};
      end
    end
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    rdata_shifted = dmem.dmem_rdata >> {byte_off, 3'b000};
    if (is_byte)
      load_data = {{24{is_signed & rdata_shifted[7]}}, rdata_shifted[7:0]};
    else if (is_half)
      load_data = {{16{is_signed & rdata_shifted[15]}}, rdata_shifted[15:0]};
    else
      load_data = dmem.dmem_rdata;
    wb_data = MemtoReg1_PR ? load_data : aluResult1_PR;
  end

  // Forwarding taps; load results are not available until WB.
  assign Data1_MEM          = aluResult1_PR;
  assign writeRegister1_MEM = writeRegister1_PR;
  assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

  // Access FSM and MEM/WB register; a stalled cycle loads a bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state             <= IDLE;
      Data1_WB          <= 32'd0;
      writeRegister1_WB <= 5'd0;
      do_writeback1_WB  <= 1'b0;
      mem_fault         <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (dmem.dmem_req && !dmem.dmem_ready) state <= WAIT;
        WAIT:    if (dmem.dmem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      mem_fault <= misaligned;
      if (stall_out) begin
        do_writeback1_WB <= 1'b0;
      end else begin
        Data1_WB          <= wb_data;
        writeRegister1_WB <= writeRegister1_PR;
        do_writeback1_WB  <= do_writeback1_PR & ~misaligned;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs,
// a monitor pops and compares whenever the stage presents a result or fault.
`timescale 1ns/1ps
module tb_mem_stage;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        fault;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic [31:0] aluResult1_PR;
  logic [31:0] readDataB1_PR;
  logic [31:0] Instr1_PR;
  logic [4:0]  writeRegister1_PR;
  logic        do_writeback1_PR;
  logic        MemRead1_PR;
  logic        MemWrite1_PR;
  logic        MemtoReg1_PR;
  logic        stall_out;
  logic [31:0] Data1_MEM;
  logic [4:0]  writeRegister1_MEM;
  logic        do_writeback1_MEM;
  logic [31:0] Data1_WB;
  logic [4:0]  writeRegister1_WB;
  logic        do_writeback1_WB;
  logic        mem_fault;

  mem_stage_if dmem_bus ();

  mem_stage dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .aluResult1_PR      (aluResult1_PR),
    .readDataB1_PR      (readDataB1_PR),
    .Instr1_PR          (Instr1_PR),
    .writeRegister1_PR  (writeRegister1_PR),
    .do_writeback1_PR   (do_writeback1_PR),
    .MemRead1_PR        (MemRead1_PR),
    .MemWrite1_PR       (MemWrite1_PR),
    .MemtoReg1_PR       (MemtoReg1_PR),
    .dmem               (dmem_bus.master),
    .stall_out          (stall_out),
    .Data1_MEM          (Data1_MEM),
    .writeRegister1_MEM (writeRegister1_MEM),
    .do_writeback1_MEM  (do_writeback1_MEM),
    .Data1_WB           (Data1_WB),
    .writeRegister1_WB  (writeRegister1_WB),
    .do_writeback1_WB   (do_writeback1_WB),
    .mem_fault          (mem_fault)
  );

  localparam logic [31:0] OP_LB  = 32'h8000_0000;
  localparam logic [31:0] OP_LH  = 32'h8400_0000;
  localparam logic [31:0] OP_LW  = 32'h8C00_0000;
  localparam logic [31:0] OP_LBU = 32'h9000_0000;
  localparam logic [31:0] OP_LHU = 32'h9400_0000;
  localparam logic [31:0] OP_SB  = 32'hA000_0000;
  localparam logic [31:0] OP_SH  = 32'hA400_0000;
  localparam logic [31:0] OP_SW  = 32'hAC00_0000;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] instr,
                       input logic [4:0] wr, input logic wb, input logic rd, input logic we,
                       input logic m2r, input logic rdy, input logic [31:0] rdat);
    aluResult1_PR        = alu;
    readDataB1_PR        = rt;
    Instr1_PR            = instr;
    writeRegister1_PR    = wr;
    do_writeback1_PR     = wb;
    MemRead1_PR          = rd;
    MemWrite1_PR         = we;
    MemtoReg1_PR         = m2r;
    dmem_bus.dmem_ready  = rdy;
    dmem_bus.dmem_rdata  = rdat;
  endtask

  task automatic nop();
    drive(32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push(input logic [31:0] data, input logic [4:0] wreg, input logic fault);
    exp_t e;
    e.data  = data;
    e.wreg  = wreg;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  // Monitor: every visible write-back or fault must match the next expectation.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (RESET && (do_writeback1_WB || mem_fault)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: wb=%0b fault=%0b data=0x%08h at %0t",
                 do_writeback1_WB, mem_fault, Data1_WB, $time);
      end else begin
        e = exp_q.pop_front();
        check("wb_fault", 32'(mem_fault), 32'(e.fault));
        check("wb_enable", 32'(do_writeback1_WB), 32'(!e.fault));
        if (!e.fault) begin
          check("wb_data", Data1_WB, e.data);
          check("wb_reg", 32'(writeRegister1_WB), 32'(e.wreg));
        end
      end
    end
  end

  initial begin
    int stall_cnt;
    RESET = 1'b0;
    nop();
    #2;
    check("rst_data_wb", Data1_WB, 32'd0);
    check("rst_reg_wb", 32'(writeRegister1_WB), 32'd0);
    check("rst_wb_en", 32'(do_writeback1_WB), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    // ALU passthrough
    @(negedge CLK);
    drive(32'h1234, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    push(32'h1234, 5'd5, 1'b0);
    #1;
    check("alu_stall", 32'(stall_out), 32'd0);
    check("alu_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("alu_fwd_data", Data1_MEM, 32'h1234);
    check("alu_fwd_wb", 32'(do_writeback1_MEM), 32'd1);
    check("alu_fwd_reg", 32'(writeRegister1_MEM), 32'd5);

    // LB sign extension, zero wait
    @(negedge CLK);
    drive(32'h103, 32'd0, OP_LB, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80FF_FFFF);
    push(32'hFFFF_FF80, 5'd7, 1'b0);
    #1;
    check("lb_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("lb_addr", dmem_bus.dmem_addr, 32'h100);
    check("lb_be", 32'(dmem_bus.dmem_be), 32'hF);
    check("lb_we", 32'(dmem_bus.dmem_we), 32'd0);
    check("lb_stall", 32'(stall_out), 32'd0);
    check("lb_fwd_wb", 32'(do_writeback1_MEM), 32'd0);

    // LBU same address
    @(negedge CLK);
    drive(32'h103, 32'd0, OP_LBU, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80FF_FFFF);
    push(32'h0000_0080, 5'd8, 1'b0);

    // LH / LHU at upper half
    @(negedge CLK);
    drive(32'h102, 32'd0, OP_LH, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8001_1234);
    push(32'hFFFF_8001, 5'd10, 1'b0);
    @(negedge CLK);
    drive(32'h102, 32'd0, OP_LHU, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8001_1234);
    push(32'h0000_8001, 5'd11, 1'b0);

    // SH at 0x102
    @(negedge CLK);
    drive(32'h102, 32'hAAAA_BEEF, OP_SH, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    #1;
    check("sh_be", 32'(dmem_bus.dmem_be), 32'hC);
    check("sh_wdata", dmem_bus.dmem_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(dmem_bus.dmem_we), 32'd1);
    check("sh_req", 32'(dmem_bus.dmem_req), 32'd1);

    // SB at 0x101 and SW at 0x104
    @(negedge CLK);
    drive(32'h101, 32'h1234_5678, OP_SB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    #1;
    check("sb_be", 32'(dmem_bus.dmem_be), 32'h2);
    check("sb_wdata", dmem_bus.dmem_wdata, 32'h7878_7878);
    @(negedge CLK);
    drive(32'h104, 32'h1234_5678, OP_SW, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    #1;
    check("sw_be", 32'(dmem_bus.dmem_be), 32'hF);
    check("sw_wdata", dmem_bus.dmem_wdata, 32'h1234_5678);
    check("sw_addr", dmem_bus.dmem_addr, 32'h104);

    // Unknown opcode with MemRead behaves as LW
    @(negedge CLK);
    drive(32'h300, 32'd0, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1122_3344);
    push(32'h1122_3344, 5'd12, 1'b0);

    @(negedge CLK);
    nop();

    // 3-wait LW at 0x200
    @(negedge CLK);
    drive(32'h200, 32'd0, OP_LW, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_DEAD);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_out) stall_cnt++;
      check("wait_req", 32'(dmem_bus.dmem_req), 32'd1);
      check("wait_addr", dmem_bus.dmem_addr, 32'h200);
      check("wait_wb_bubble", 32'(do_writeback1_WB), 32'd0);
      @(negedge CLK);
    end
    dmem_bus.dmem_ready = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    push(32'hCAFE_F00D, 5'd9, 1'b0);
    #1;
    check("wait_stall_count", 32'(stall_cnt), 32'd3);
    check("wait_done_stall", 32'(stall_out), 32'd0);
    check("wait_done_req", 32'(dmem_bus.dmem_req), 32'd1);
    @(negedge CLK);
    nop();
    #1;
    check("after_wait_req", 32'(dmem_bus.dmem_req), 32'd0);

    // Misaligned LW at 0x202
    @(negedge CLK);
    drive(32'h202, 32'd0, OP_LW, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5555_5555);
    push(32'd0, 5'd13, 1'b1);
    #1;
    check("mis_lw_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("mis_lw_stall", 32'(stall_out), 32'd0);
    @(negedge CLK);
    nop();

    // Misaligned LH at 0x101, then read+write together
    @(negedge CLK);
    drive(32'h101, 32'd0, OP_LH, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    push(32'd0, 5'd14, 1'b1);
    #1;
    check("mis_lh_req", 32'(dmem_bus.dmem_req), 32'd0);
    @(negedge CLK);
    drive(32'h100, 32'd0, OP_LW, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    push(32'd0, 5'd15, 1'b1);
    #1;
    check("mis_rw_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("mis_rw_stall", 32'(stall_out), 32'd0);
    @(negedge CLK);
    nop();
    @(negedge CLK);

    // Reset during WAIT
    drive(32'h400, 32'd0, OP_LW, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    @(posedge CLK);
    #2;
    check("rw_stall_before", 32'(stall_out), 32'd1);
    check("rw_queue_empty", 32'(exp_q.size()), 32'd0);
    RESET = 1'b0;
    #1;
    check("rw_req", 32'(dmem_bus.dmem_req), 32'd0);
    check("rw_stall", 32'(stall_out), 32'd0);
    check("rw_data_wb", Data1_WB, 32'd0);
    check("rw_reg_wb", 32'(writeRegister1_WB), 32'd0);
    check("rw_wb_en", 32'(do_writeback1_WB), 32'd0);
    check("rw_fault", 32'(mem_fault), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    drive(32'h404, 32'd0, OP_LW, 5'd17, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5A5A_5A5A);
    push(32'h5A5A_5A5A, 5'd17, 1'b0);
    #1;
    check("post_rst_req", 32'(dmem_bus.dmem_req), 32'd1);
    check("post_rst_stall", 32'(stall_out), 32'd0);
    @(negedge CLK);
    nop();
    repeat (3) @(negedge CLK);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
